// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer:
// opcodes, source-select codes, flag bit positions and small decode helpers.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SBC  = 4'd3;
  localparam logic [3:0] OP_CP   = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_BSL  = 4'd8;
  localparam logic [3:0] OP_BSR  = 4'd9;
  localparam logic [3:0] OP_SWAP = 4'd10;

  localparam logic [2:0] SRC_B  = 3'd0;
  localparam logic [2:0] SRC_C  = 3'd1;
  localparam logic [2:0] SRC_D  = 3'd2;
  localparam logic [2:0] SRC_E  = 3'd3;
  localparam logic [2:0] SRC_H  = 3'd4;
  localparam logic [2:0] SRC_L  = 3'd5;
  localparam logic [2:0] SRC_HL = 3'd6;
  localparam logic [2:0] SRC_A  = 3'd7;

  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_MEMWB = 2'd3
  } seq_state_t;

  // Shift/swap ops operate on the source operand in place rather than on A.
  function automatic logic is_shift(input logic [3:0] op);
    return (op >= OP_BSL) && (op <= OP_SWAP);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op, input logic imm);
    return (op > OP_SWAP) || (is_shift(op) && imm);
  endfunction

endpackage

// File: rtl/alu_seq.sv
// Issue/writeback sequencer for the 8-bit ALU: accepts one decoded ALU
// instruction, gathers its operand, runs the ALU and writes results back.
module alu_seq
  import alu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  instr_op,
  input  logic [2:0]  instr_src,
  input  logic        instr_imm,
  input  logic [7:0]  imm8,
  input  logic [7:0]  a_rdata,
  input  logic [7:0]  f_rdata,
  input  logic [15:0] hl,
  output logic [2:0]  rf_rd_addr,
  input  logic [7:0]  rf_rd_data,
  output logic        rf_we,
  output logic [2:0]  rf_wr_addr,
  output logic [7:0]  rf_wdata,
  output logic        a_we,
  output logic [7:0]  a_wdata,
  output logic        f_we,
  output logic [7:0]  f_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  output logic        alu_cin,
  input  logic [15:0] alu_res,
  input  logic [7:0]  alu_flags,
  output logic        busy,
  output logic        err
);

  localparam logic [15:0] TO_LIMIT = 16'(ACK_TIMEOUT);

  seq_state_t  r_state;
  logic [3:0]  r_op;
  logic [2:0]  r_src;
  logic [7:0]  r_a;
  logic        r_c;
  logic [15:0] r_hl;
  logic [7:0]  r_opnd;
  logic [7:0]  r_res;
  logic [15:0] r_cnt;
  logic        r_err;

  logic        w_timeout;
  logic        w_shift;
  logic        w_unused;

  assign w_timeout = (ACK_TIMEOUT != 0) && (r_cnt == TO_LIMIT - 16'd1);
  assign w_shift   = is_shift(r_op);
  assign w_unused  = ^{f_rdata[7:5], f_rdata[3:0], alu_res[15:8]};

  // An ack landing on the timeout cycle wins; the counter restarts on each bus phase entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_src   <= '0;
      r_a     <= '0;
      r_c     <= 1'b0;
      r_hl    <= '0;
      r_opnd  <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            if (is_illegal(instr_op, instr_imm)) begin
              r_err <= 1'b1;
            end else begin
              r_op   <= instr_op;
              r_src  <= instr_src;
              r_a    <= a_rdata;
              r_c    <= f_rdata[FLAG_C];
              r_hl   <= hl;
              r_opnd <= instr_imm ? imm8 :
                        (instr_src == SRC_A) ? a_rdata : rf_rd_data;
              r_cnt  <= '0;
              r_state <= (!instr_imm && instr_src == SRC_HL) ? S_FETCH : S_EXEC;
            end
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            r_opnd  <= mem_rdata;
            r_state <= S_EXEC;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_EXEC: begin
          if (w_shift && r_src == SRC_HL) begin
            r_res   <= alu_res[7:0];
            r_cnt   <= '0;
            r_state <= S_MEMWB;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_MEMWB: begin
          if (mem_ack) begin
            r_state <= S_IDLE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from registered state; EXEC writes back the ALU's combinational result.
  always_comb begin
    instr_ready = 1'b0;
    rf_rd_addr  = '0;
    rf_we       = 1'b0;
    rf_wr_addr  = '0;
    rf_wdata    = '0;
    a_we        = 1'b0;
    a_wdata     = '0;
    f_we        = 1'b0;
    f_wdata     = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = '0;
    alu_cin     = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        rf_rd_addr  = instr_src;
      end
      S_FETCH: mem_req = 1'b1;
      S_EXEC: begin
        alu_op  = r_op;
        alu_a   = w_shift ? {8'h00, r_opnd} : {8'h00, r_a};
        alu_b   = w_shift ? 16'h0000 : {8'h00, r_opnd};
        alu_cin = (r_op == OP_ADC || r_op == OP_SBC) ? r_c : 1'b0;
        f_we    = 1'b1;
        f_wdata = alu_flags & 8'hF0;
        if (w_shift) begin
          if (r_src == SRC_A) begin
            a_we    = 1'b1;
            a_wdata = alu_res[7:0];
          end else if (r_src != SRC_HL) begin
            rf_we      = 1'b1;
            rf_wr_addr = r_src;
            rf_wdata   = alu_res[7:0];
          end
        end else if (r_op != OP_CP) begin
          a_we    = 1'b1;
          a_wdata = alu_res[7:0];
        end
      end
      S_MEMWB: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_addr  = r_hl;
  assign mem_wdata = r_res;
  assign busy      = (r_state != S_IDLE);
  assign err       = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural 8-bit ALU and register file
// standing in for the real datapath neighbours.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk, rst_n;
  logic        instr_valid, instr_ready;
  logic [3:0]  instr_op;
  logic [2:0]  instr_src;
  logic        instr_imm;
  logic [7:0]  imm8, a_rdata, f_rdata;
  logic [15:0] hl;
  logic [2:0]  rf_rd_addr;
  logic [7:0]  rf_rd_data;
  logic        rf_we;
  logic [2:0]  rf_wr_addr;
  logic [7:0]  rf_wdata;
  logic        a_we;
  logic [7:0]  a_wdata;
  logic        f_we;
  logic [7:0]  f_wdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        alu_cin;
  logic [15:0] alu_res;
  logic [7:0]  alu_flags;
  logic        busy, err;

  int tests = 0;
  int failures = 0;

  logic [7:0] regs [8];
  assign rf_rd_data = regs[rf_rd_addr];

  alu_seq #(.ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_src(instr_src), .instr_imm(instr_imm), .imm8(imm8),
    .a_rdata(a_rdata), .f_rdata(f_rdata), .hl(hl),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wdata(rf_wdata),
    .a_we(a_we), .a_wdata(a_wdata), .f_we(f_we), .f_wdata(f_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_flags(alu_flags),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: ZNHC flags in bits 7:4, low nibble zero.
  logic [8:0] m_wide;
  logic [4:0] m_nib;
  logic [7:0] m_r;
  logic       m_n, m_h, m_c;
  always_comb begin
    m_wide = '0;
    m_nib  = '0;
    m_r    = '0;
    m_n    = 1'b0;
    m_h    = 1'b0;
    m_c    = 1'b0;
    case (alu_op)
      OP_ADD, OP_ADC: begin
        m_wide = {1'b0, alu_a[7:0]} + {1'b0, alu_b[7:0]} + {8'h00, alu_cin};
        m_nib  = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'h0, alu_cin};
        m_r = m_wide[7:0]; m_c = m_wide[8]; m_h = m_nib[4];
      end
      OP_SUB, OP_SBC, OP_CP: begin
        m_wide = {1'b0, alu_a[7:0]} - {1'b0, alu_b[7:0]} - {8'h00, alu_cin};
        m_nib  = {1'b0, alu_a[3:0]} - {1'b0, alu_b[3:0]} - {4'h0, alu_cin};
        m_r = m_wide[7:0]; m_c = m_wide[8]; m_h = m_nib[4]; m_n = 1'b1;
      end
      OP_AND:  begin m_r = alu_a[7:0] & alu_b[7:0]; m_h = 1'b1; end
      OP_OR:   m_r = alu_a[7:0] | alu_b[7:0];
      OP_XOR:  m_r = alu_a[7:0] ^ alu_b[7:0];
      OP_BSL:  begin m_r = {alu_a[6:0], 1'b0}; m_c = alu_a[7]; end
      OP_BSR:  begin m_r = {1'b0, alu_a[7:1]}; m_c = alu_a[0]; end
      OP_SWAP: m_r = {alu_a[3:0], alu_a[7:4]};
      default: m_r = 8'h00;
    endcase
  end
  assign alu_res   = {8'h00, m_r};
  assign alu_flags = {(m_r == 8'h00), m_n, m_h, m_c, 4'h0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] src,
                       input logic imm, input logic [7:0] val);
    instr_op    = op;
    instr_src   = src;
    instr_imm   = imm;
    imm8        = val;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++; if (instr_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b want 1", instr_ready); end
    tests++; if ({busy, err, mem_req, a_we, f_we, rf_we} !== 6'b0) begin failures++; $display("[TB] FAIL reset_ctrl: got %b want 000000", {busy, err, mem_req, a_we, f_we, rf_we}); end
    tests++; if ({mem_addr, mem_wdata, alu_a} !== 40'h0) begin failures++; $display("[TB] FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, alu_a}); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_add_reg();
    regs[0] = 8'hC6; a_rdata = 8'h3A; f_rdata = 8'h00;
    issue(OP_ADD, SRC_B, 1'b0, 8'h00);
    tests++; if (alu_a !== 16'h003A) begin failures++; $display("[TB] FAIL add_alu_a: got %h want 003a", alu_a); end
    tests++; if (alu_b !== 16'h00C6) begin failures++; $display("[TB] FAIL add_alu_b: got %h want 00c6", alu_b); end
    tests++; if ({a_we, a_wdata} !== {1'b1, 8'h00}) begin failures++; $display("[TB] FAIL add_a_write: got %b/%h want 1/00", a_we, a_wdata); end
    tests++; if ({f_we, f_wdata} !== {1'b1, 8'hB0}) begin failures++; $display("[TB] FAIL add_f_write: got %b/%h want 1/b0", f_we, f_wdata); end
    tests++; if ({instr_ready, rf_we, busy} !== 3'b001) begin failures++; $display("[TB] FAIL add_exec_ctrl: got %b want 001", {instr_ready, rf_we, busy}); end
    tick();
    tests++; if ({instr_ready, a_we, f_we} !== 3'b100) begin failures++; $display("[TB] FAIL add_done: got %b want 100", {instr_ready, a_we, f_we}); end
  endtask

  task automatic test_cp_imm();
    a_rdata = 8'h10; f_rdata = 8'h00;
    issue(OP_CP, SRC_B, 1'b1, 8'h10);
    tests++; if (alu_b !== 16'h0010) begin failures++; $display("[TB] FAIL cp_alu_b: got %h want 0010", alu_b); end
    tests++; if ({f_we, f_wdata} !== {1'b1, 8'hC0}) begin failures++; $display("[TB] FAIL cp_f_write: got %b/%h want 1/c0", f_we, f_wdata); end
    tests++; if ({a_we, rf_we} !== 2'b00) begin failures++; $display("[TB] FAIL cp_no_a_write: got %b want 00", {a_we, rf_we}); end
    tick();
  endtask

  task automatic test_sbc_imm();
    a_rdata = 8'h05; f_rdata = 8'h10;
    issue(OP_SBC, SRC_B, 1'b1, 8'h02);
    tests++; if (alu_cin !== 1'b1) begin failures++; $display("[TB] FAIL sbc_cin: got %b want 1", alu_cin); end
    tests++; if ({a_we, a_wdata} !== {1'b1, 8'h02}) begin failures++; $display("[TB] FAIL sbc_a_write: got %b/%h want 1/02", a_we, a_wdata); end
    tests++; if (f_wdata !== 8'h40) begin failures++; $display("[TB] FAIL sbc_flags: got %h want 40", f_wdata); end
    tick();
    f_rdata = 8'h00;
  endtask

  task automatic test_shift_reg();
    regs[1] = 8'h81; f_rdata = 8'h10;
    issue(OP_BSL, SRC_C, 1'b0, 8'h00);
    tests++; if ({alu_a, alu_b, alu_cin} !== {16'h0081, 16'h0000, 1'b0}) begin failures++; $display("[TB] FAIL bsl_operands: got %h/%h/%b want 0081/0000/0", alu_a, alu_b, alu_cin); end
    tests++; if ({rf_we, rf_wr_addr, rf_wdata} !== {1'b1, 3'd1, 8'h02}) begin failures++; $display("[TB] FAIL bsl_rf_write: got %b/%0d/%h want 1/1/02", rf_we, rf_wr_addr, rf_wdata); end
    tests++; if ({a_we, f_we, f_wdata} !== {1'b0, 1'b1, 8'h10}) begin failures++; $display("[TB] FAIL bsl_af: got %b/%b/%h want 0/1/10", a_we, f_we, f_wdata); end
    tick();
    a_rdata = 8'h01; f_rdata = 8'h00;
    issue(OP_BSR, SRC_A, 1'b0, 8'h00);
    tests++; if ({a_we, a_wdata, rf_we} !== {1'b1, 8'h00, 1'b0}) begin failures++; $display("[TB] FAIL bsr_a_write: got %b/%h/%b want 1/00/0", a_we, a_wdata, rf_we); end
    tests++; if (f_wdata !== 8'h90) begin failures++; $display("[TB] FAIL bsr_flags: got %h want 90", f_wdata); end
    tick();
  endtask

  task automatic test_swap_hl();
    hl = 16'hC000; mem_rdata = 8'hF1;
    issue(OP_SWAP, SRC_HL, 1'b0, 8'h00);
    tests++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'hC000}) begin failures++; $display("[TB] FAIL swap_fetch: got %b/%b/%h want 1/0/c000", mem_req, mem_we, mem_addr); end
    tick(); tick(); tick();
    tests++; if ({mem_req, busy} !== 2'b11) begin failures++; $display("[TB] FAIL swap_wait: got %b want 11", {mem_req, busy}); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tests++; if ({alu_op, alu_a, alu_b} !== {OP_SWAP, 16'h00F1, 16'h0000}) begin failures++; $display("[TB] FAIL swap_exec_alu: got %h/%h/%h want a/00f1/0000", alu_op, alu_a, alu_b); end
    tests++; if ({f_we, f_wdata, a_we, rf_we, mem_req} !== {1'b1, 8'h00, 3'b000}) begin failures++; $display("[TB] FAIL swap_exec_wr: got %b/%h/%b/%b/%b want 1/00/0/0/0", f_we, f_wdata, a_we, rf_we, mem_req); end
    tick();
    tests++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'hC000, 8'h1F}) begin failures++; $display("[TB] FAIL swap_memwb: got %b/%b/%h/%h want 1/1/c000/1f", mem_req, mem_we, mem_addr, mem_wdata); end
    tests++; if ({a_we, f_we, rf_we} !== 3'b000) begin failures++; $display("[TB] FAIL swap_memwb_strobes: got %b want 000", {a_we, f_we, rf_we}); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tests++; if ({busy, mem_req, err, instr_ready} !== 4'b0001) begin failures++; $display("[TB] FAIL swap_done: got %b want 0001", {busy, mem_req, err, instr_ready}); end
  endtask

  task automatic test_timeout();
    int  cycles;
    logic wrote;
    cycles = 0;
    wrote  = 1'b0;
    hl = 16'h8000;
    issue(OP_ADD, SRC_HL, 1'b0, 8'h00);
    while (mem_req && cycles < 40) begin
      cycles++;
      wrote = wrote | a_we | f_we | rf_we;
      tick();
    end
    tests++; if (cycles != 15) begin failures++; $display("[TB] FAIL timeout_cycles: got %0d want 15", cycles); end
    tests++; if ({err, busy, wrote} !== 3'b100) begin failures++; $display("[TB] FAIL timeout_abort: got %b want 100", {err, busy, wrote}); end
    tick();
    tests++; if ({err, a_we, f_we} !== 3'b000) begin failures++; $display("[TB] FAIL timeout_err_pulse: got %b want 000", {err, a_we, f_we}); end
  endtask

  task automatic test_illegal();
    issue(4'd12, SRC_B, 1'b0, 8'h00);
    tests++; if ({err, busy, instr_ready} !== 3'b101) begin failures++; $display("[TB] FAIL op12_err: got %b want 101", {err, busy, instr_ready}); end
    tests++; if ({a_we, f_we, rf_we, mem_req} !== 4'b0000) begin failures++; $display("[TB] FAIL op12_strobes: got %b want 0000", {a_we, f_we, rf_we, mem_req}); end
    tick();
    tests++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL op12_pulse: got %b want 0", err); end
    issue(OP_BSL, SRC_B, 1'b1, 8'h55);
    tests++; if ({err, busy} !== 2'b10) begin failures++; $display("[TB] FAIL bsl_imm_err: got %b want 10", {err, busy}); end
    tick();
    issue(4'd11, SRC_C, 1'b0, 8'h00);
    tests++; if ({err, busy, f_we} !== 3'b100) begin failures++; $display("[TB] FAIL op11_err: got %b want 100", {err, busy, f_we}); end
    tick();
  endtask

  task automatic test_back_to_back();
    a_rdata = 8'h0F;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tests++; if ({busy, err} !== 2'b00) begin failures++; $display("[TB] FAIL idle_ack_ignored: got %b want 00", {busy, err}); end
    instr_op = OP_XOR; instr_src = SRC_B; instr_imm = 1'b1; imm8 = 8'hFF; instr_valid = 1'b1;
    tick();
    tests++; if ({instr_ready, a_we, a_wdata} !== {1'b0, 1'b1, 8'hF0}) begin failures++; $display("[TB] FAIL b2b_first: got %b/%b/%h want 0/1/f0", instr_ready, a_we, a_wdata); end
    instr_op = OP_AND; imm8 = 8'h00;
    tick();
    tests++; if ({instr_ready, a_we} !== 2'b10) begin failures++; $display("[TB] FAIL b2b_gap: got %b want 10", {instr_ready, a_we}); end
    tick();
    instr_valid = 1'b0;
    tests++; if ({a_we, a_wdata, f_wdata} !== {1'b1, 8'h00, 8'hA0}) begin failures++; $display("[TB] FAIL b2b_second: got %b/%h/%h want 1/00/a0", a_we, a_wdata, f_wdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    hl = 16'h1234; mem_rdata = 8'h02;
    issue(OP_BSR, SRC_HL, 1'b0, 8'h00);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    tests++; if ({mem_req, mem_we, mem_wdata} !== {2'b11, 8'h01}) begin failures++; $display("[TB] FAIL rst_mid_memwb: got %b/%b/%h want 1/1/01", mem_req, mem_we, mem_wdata); end
    rst_n = 1'b0;
    #1;
    tests++; if ({mem_req, mem_we, busy, err, a_we, f_we, rf_we} !== 7'b0) begin failures++; $display("[TB] FAIL rst_mid_ctrl: got %b want 0000000", {mem_req, mem_we, busy, err, a_we, f_we, rf_we}); end
    tests++; if ({mem_addr, mem_wdata} !== 24'h0) begin failures++; $display("[TB] FAIL rst_mid_data: got %h want 0", {mem_addr, mem_wdata}); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    a_rdata = 8'h3A;
    issue(OP_ADD, SRC_B, 1'b1, 8'h01);
    tests++; if ({a_we, a_wdata, f_wdata} !== {1'b1, 8'h3B, 8'h00}) begin failures++; $display("[TB] FAIL rst_mid_next: got %b/%h/%h want 1/3b/00", a_we, a_wdata, f_wdata); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 8'h00;
    instr_valid = 1'b0; instr_op = '0; instr_src = '0; instr_imm = 1'b0; imm8 = '0;
    a_rdata = '0; f_rdata = '0; hl = '0; mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_add_reg();
    test_cp_imm();
    test_sbc_imm();
    test_shift_reg();
    test_swap_hl();
    test_timeout();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
